// File: rtl/int_redirect_ctrl.sv
// int_redirect_ctrl: interrupt entry/return sequencer driving the next-PC mux select and target.
module int_redirect_ctrl #(
  parameter int          NUM_IRQ = 4,
  parameter logic [31:0] VECTOR  = 32'h0000_0004
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic [31:0]        pc_in,
  input  logic               stall,
  input  logic               eret,
  output logic               redirect,
  output logic [31:0]        redirect_pc,
  output logic               flush,
  output logic               in_isr,
  output logic [31:0]        epc,
  output logic [NUM_IRQ-1:0] cause,
  output logic [NUM_IRQ-1:0] mask
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] TAKE    = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;
  localparam logic [1:0] RET     = 2'd3;

  logic [1:0]         state;
  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] sel;

  // pend sees the mask before any same-cycle write; sel isolates the lowest set bit
  assign pend = irq & mask;
  assign sel  = pend & (~pend + NUM_IRQ'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      epc   <= '0;
      cause <= '0;
      mask  <= '0;
    end else begin
      if (mask_we) mask <= mask_wdata;
      case (state)
        IDLE:
          if (|pend && !stall) begin
            epc   <= pc_in;
            cause <= sel;
            state <= TAKE;
          end
        TAKE:    if (!stall) state <= SERVICE;
        SERVICE: if (eret && !stall) state <= RET;
        default:
          if (!stall) begin
            cause <= '0;
            state <= IDLE;
          end
      endcase
    end
  end

  assign redirect    = (state == TAKE) || (state == RET);
  assign flush       = redirect;
  assign in_isr      = (state == SERVICE) || (state == RET);
  assign redirect_pc = (state == TAKE) ? VECTOR : (state == RET) ? epc : '0;
endmodule

// File: tb/tb_int_redirect_ctrl.sv
// tb_int_redirect_ctrl: directed vector table plus randomized run against a behavioural model.
module tb_int_redirect_ctrl;
  localparam logic [31:0] VEC = 32'h0000_0004;

  logic        clk = 0;
  logic        rst_n;
  logic [3:0]  irq, mask_wdata, cause, mask;
  logic        mask_we, stall, eret;
  logic [31:0] pc_in, redirect_pc, epc;
  logic        redirect, flush, in_isr;

  int applied = 0;
  int miscompares = 0;

  int_redirect_ctrl #(.NUM_IRQ(4), .VECTOR(VEC)) dut (
    .clk(clk), .rst_n(rst_n), .irq(irq), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .pc_in(pc_in), .stall(stall), .eret(eret), .redirect(redirect),
    .redirect_pc(redirect_pc), .flush(flush), .in_isr(in_isr), .epc(epc),
    .cause(cause), .mask(mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  irq;
    logic        we;
    logic [3:0]  wd;
    logic [31:0] pc;
    logic        stall;
    logic        eret;
    logic        x_red;
    logic [31:0] x_rpc;
    logic        x_isr;
    logic [3:0]  x_cause;
    logic [31:0] x_epc;
    logic [3:0]  x_mask;
  } vec_t;

  vec_t vecs[$];

  // model: handler progress tracked as plain flags, not a state code
  logic        m_entering, m_active, m_returning;
  logic [31:0] m_epc;
  logic [3:0]  m_cause, m_mask;

  function automatic logic [3:0] lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return 4'(1 << i);
    return 4'd0;
  endfunction

  task automatic model_reset();
    m_entering = 0; m_active = 0; m_returning = 0;
    m_epc = 0; m_cause = 0; m_mask = 0;
  endtask

  task automatic model_step(input logic [3:0] i_irq, input logic we, input logic [3:0] wd,
                            input logic [31:0] pc, input logic st, input logic er);
    if (m_entering) begin
      if (!st) begin m_entering = 0; m_active = 1; end
    end else if (m_returning) begin
      if (!st) begin m_returning = 0; m_active = 0; m_cause = 0; end
    end else if (m_active) begin
      if (er && !st) m_returning = 1;
    end else if ((i_irq & m_mask) != 0 && !st) begin
      m_entering = 1; m_epc = pc; m_cause = lowest(i_irq & m_mask);
    end
    if (we) m_mask = wd;
  endtask

  task automatic check(input string name, input logic red, input logic [31:0] rpc,
                       input logic isr, input logic [3:0] cs, input logic [31:0] ep,
                       input logic [3:0] mk);
    logic [74:0] got, want;
    got  = {redirect, redirect_pc, flush, in_isr, epc, cause, mask};
    want = {red, rpc, red, isr, ep, cs, mk};
    applied++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got red=%b rpc=%h flush=%b isr=%b epc=%h cause=%b mask=%b, want red=%b rpc=%h flush=%b isr=%b epc=%h cause=%b mask=%b",
               name, redirect, redirect_pc, flush, in_isr, epc, cause, mask,
               red, rpc, red, isr, ep, cs, mk);
    end
  endtask

  task automatic drive(input logic [3:0] i_irq, input logic we, input logic [3:0] wd,
                       input logic [31:0] pc, input logic st, input logic er);
    irq = i_irq; mask_we = we; mask_wdata = wd; pc_in = pc; stall = st; eret = er;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t v(input logic [3:0] i, input logic we, input logic [3:0] wd,
                             input logic [31:0] pc, input logic st, input logic er,
                             input logic r, input logic [31:0] rp, input logic is,
                             input logic [3:0] c, input logic [31:0] e, input logic [3:0] m);
    vec_t t;
    t.irq = i; t.we = we; t.wd = wd; t.pc = pc; t.stall = st; t.eret = er;
    t.x_red = r; t.x_rpc = rp; t.x_isr = is; t.x_cause = c; t.x_epc = e; t.x_mask = m;
    return t;
  endfunction

  initial begin
    //            irq   we wd    pc     st er  red rpc    isr cause epc    mask
    vecs.push_back(v(4'b0010,1,4'b0010,32'h40, 0,0, 0,32'h0, 0,4'b0000,32'h0, 4'b0010));
    vecs.push_back(v(4'b0010,0,4'b0000,32'h40, 0,0, 1,VEC,   0,4'b0010,32'h40,4'b0010));
    vecs.push_back(v(4'b0000,0,4'b0000,32'h0,  0,0, 0,32'h0, 1,4'b0010,32'h40,4'b0010));
    vecs.push_back(v(4'b0000,0,4'b0000,32'h0,  1,1, 0,32'h0, 1,4'b0010,32'h40,4'b0010));
    vecs.push_back(v(4'b0000,0,4'b0000,32'h0,  0,1, 1,32'h40,1,4'b0010,32'h40,4'b0010));
    vecs.push_back(v(4'b0000,0,4'b0000,32'h0,  0,0, 0,32'h0, 0,4'b0000,32'h40,4'b0010));
    vecs.push_back(v(4'b0000,0,4'b0000,32'h0,  0,1, 0,32'h0, 0,4'b0000,32'h40,4'b0010));
    vecs.push_back(v(4'b1100,1,4'b1111,32'h80, 0,0, 0,32'h0, 0,4'b0000,32'h40,4'b1111));
    vecs.push_back(v(4'b1100,0,4'b0000,32'h80, 0,0, 1,VEC,   0,4'b0100,32'h80,4'b1111));
    vecs.push_back(v(4'b0000,0,4'b0000,32'h0,  1,0, 1,VEC,   0,4'b0100,32'h80,4'b1111));
    vecs.push_back(v(4'b0000,0,4'b0000,32'h0,  1,0, 1,VEC,   0,4'b0100,32'h80,4'b1111));
    vecs.push_back(v(4'b0000,0,4'b0000,32'h0,  1,0, 1,VEC,   0,4'b0100,32'h80,4'b1111));
    vecs.push_back(v(4'b0000,0,4'b0000,32'h0,  0,0, 0,32'h0, 1,4'b0100,32'h80,4'b1111));
    vecs.push_back(v(4'b1111,0,4'b0000,32'h0,  0,0, 0,32'h0, 1,4'b0100,32'h80,4'b1111));
    vecs.push_back(v(4'b1111,0,4'b0000,32'h0,  0,1, 1,32'h80,1,4'b0100,32'h80,4'b1111));
    vecs.push_back(v(4'b0001,0,4'b0000,32'h0,  0,0, 0,32'h0, 0,4'b0000,32'h80,4'b1111));
    vecs.push_back(v(4'b0001,0,4'b0000,32'hc0, 0,0, 1,VEC,   0,4'b0001,32'hc0,4'b1111));
    vecs.push_back(v(4'b0000,0,4'b0000,32'h0,  0,0, 0,32'h0, 1,4'b0001,32'hc0,4'b1111));
    vecs.push_back(v(4'b0000,0,4'b0000,32'h0,  0,1, 1,32'hc0,1,4'b0001,32'hc0,4'b1111));
    vecs.push_back(v(4'b0000,0,4'b0000,32'h0,  0,0, 0,32'h0, 0,4'b0000,32'hc0,4'b1111));
    vecs.push_back(v(4'b0000,1,4'b0000,32'h0,  0,0, 0,32'h0, 0,4'b0000,32'hc0,4'b0000));
    vecs.push_back(v(4'b1111,0,4'b0000,32'h0,  0,0, 0,32'h0, 0,4'b0000,32'hc0,4'b0000));
    vecs.push_back(v(4'b1111,0,4'b0000,32'h0,  0,0, 0,32'h0, 0,4'b0000,32'hc0,4'b0000));
    vecs.push_back(v(4'b0001,1,4'b0001,32'h140,0,0, 0,32'h0, 0,4'b0000,32'hc0,4'b0001));
    vecs.push_back(v(4'b0001,0,4'b0000,32'h144,0,1, 1,VEC,   0,4'b0001,32'h144,4'b0001));
    vecs.push_back(v(4'b0000,1,4'b0000,32'h0,  0,0, 0,32'h0, 1,4'b0001,32'h144,4'b0000));
    vecs.push_back(v(4'b0000,0,4'b0000,32'h0,  0,1, 1,32'h144,1,4'b0001,32'h144,4'b0000));
    vecs.push_back(v(4'b0000,0,4'b0000,32'h0,  0,0, 0,32'h0, 0,4'b0000,32'h144,4'b0000));
    vecs.push_back(v(4'b0000,1,4'b1111,32'h0,  0,0, 0,32'h0, 0,4'b0000,32'h144,4'b1111));
    vecs.push_back(v(4'b0001,0,4'b0000,32'h200,0,0, 1,VEC,   0,4'b0001,32'h200,4'b1111));

    rst_n = 0; irq = 0; mask_we = 0; mask_wdata = 0; pc_in = 0; stall = 0; eret = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_values", 0, 32'h0, 0, 4'b0, 32'h0, 4'b0);
    rst_n = 1;

    foreach (vecs[k])
      begin
        drive(vecs[k].irq, vecs[k].we, vecs[k].wd, vecs[k].pc, vecs[k].stall, vecs[k].eret);
        check($sformatf("vec%0d", k), vecs[k].x_red, vecs[k].x_rpc, vecs[k].x_isr,
              vecs[k].x_cause, vecs[k].x_epc, vecs[k].x_mask);
      end

    // asynchronous reset while redirecting: outputs must clear before the next edge
    irq = 0;
    #2 rst_n = 0;
    #1 check("async_reset_mid_take", 0, 32'h0, 0, 4'b0, 32'h0, 4'b0);
    @(posedge clk);
    #1 rst_n = 1;
    model_reset();

    for (int n = 0; n < 3000; n++) begin
      logic [3:0]  r_irq, r_wd;
      logic        r_we, r_st, r_er;
      logic [31:0] r_pc;
      r_irq = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
      r_we  = ($urandom_range(0, 7) == 0);
      r_wd  = 4'($urandom);
      r_pc  = $urandom & 32'hffff_fffc;
      r_st  = ($urandom_range(0, 3) == 0);
      r_er  = ($urandom_range(0, 3) == 0);
      model_step(r_irq, r_we, r_wd, r_pc, r_st, r_er);
      drive(r_irq, r_we, r_wd, r_pc, r_st, r_er);
      check($sformatf("rand%0d", n), m_entering | m_returning,
            m_entering ? VEC : m_returning ? m_epc : 32'h0,
            m_active, m_cause, m_epc, m_mask);
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
